// File: rtl/sha1_pkg.sv
// SHA-1 shared types, constants and round helpers.
// Used by sha1_core_unrolled and sha1_round.
package sha1_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL
  } sha1_fsm_t;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [159:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sha1_f(
    input logic [6:0]  t,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    unique case (1'b1)
      (t < 7'd20):
        r = (b & c) | (~b & d);
      (t >= 7'd40 && t < 7'd60):
        r = (b & c) | (b & d) | (c & d);
      default:
        r = b ^ c ^ d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sha1_k(
    input logic [6:0] t
  );
    logic [31:0] r;
    unique case (1'b1)
      (t < 7'd20):               r = K0;
      (t >= 7'd20 && t < 7'd40): r = K1;
      (t >= 7'd40 && t < 7'd60): r = K2;
      default:                   r = K3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round.
// Chained UNROLL times inside sha1_core_unrolled.
module sha1_round
  import sha1_pkg::*;
(
  input  sha1_state_t s,
  input  logic [31:0] w,
  input  logic [6:0]  t,
  output sha1_state_t n
);

  logic [31:0] tmp;

  assign tmp = rotl(s.a, 5) + sha1_f(t, s.b, s.c, s.d)
             + s.e + sha1_k(t) + w;

  assign n.a = tmp;
  assign n.b = s.a;
  assign n.c = rotl(s.b, 30);
  assign n.d = s.c;
  assign n.e = s.d;

endmodule

// File: rtl/sha1_core_unrolled.sv
// SHA-1 block compression, UNROLL rounds per clock.
// Define PREFETCH_EN to split buffer and window.
module sha1_core_unrolled
  import sha1_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load,
  input  logic [31:0]  din,
  input  logic [159:0] cv,
  input  logic         use_prev_cv,
  output logic         busy,
  output logic         ready,
  output logic [159:0] cv_next,
  output logic [31:0]  w
);

  localparam int NCYC = 80 / UNROLL;
  localparam logic [6:0] STEP = 7'(UNROLL);
  localparam logic [6:0] T_LAST = 7'(UNROLL * (NCYC - 1));

  if (UNROLL < 1 || UNROLL > 80 || (80 % UNROLL) != 0)
  begin : g_bad_unroll
    $error("sha1_core_unrolled: UNROLL must divide 80");
  end

  sha1_fsm_t   state_q;
  sha1_fsm_t   state_d;
  logic [6:0]  t_q;
  sha1_state_t st_q;
  logic [159:0] h_q;
  logic [159:0] cv_next_q;
  logic         ready_q;
  logic [31:0]  w_q;
  logic [511:0] buf_q;
  logic [511:0] win;
  logic [511:0] win_adv;
  logic [159:0] cv_sel;
  logic [159:0] cv_sum;
  logic         go;

  logic [31:0]  ws [0:UNROLL+15];
  sha1_state_t  rs [0:UNROLL];

  assign go     = (state_q == S_IDLE) && start;
  assign cv_sel = use_prev_cv ? cv_next_q : cv;

  for (genvar j = 0; j < 16; j++) begin : g_win
    assign ws[j] = win[511-32*j -: 32];
    assign win_adv[511-32*j -: 32] = ws[UNROLL+j];
  end

  for (genvar i = 0; i < UNROLL; i++) begin : g_sched
    assign ws[16+i] = rotl(ws[13+i] ^ ws[8+i]
                         ^ ws[2+i] ^ ws[i], 1);
  end

  assign rs[0] = st_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    sha1_round u_round (
      .s (rs[i]),
      .w (ws[i]),
      .t (t_q + 7'(i)),
      .n (rs[i+1])
    );
  end

  assign cv_sum = {
    h_q[159:128] + st_q.a,
    h_q[127:96]  + st_q.b,
    h_q[95:64]   + st_q.c,
    h_q[63:32]   + st_q.d,
    h_q[31:0]    + st_q.e
  };

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (t_q == T_LAST) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working state, round index, result and debug word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q       <= '0;
      st_q      <= '0;
      h_q       <= '0;
      cv_next_q <= '0;
      ready_q   <= 1'b0;
      w_q       <= '0;
    end else begin
      ready_q <= (state_q == S_FINAL);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            h_q  <= cv_sel;
            st_q <= cv_sel;
            t_q  <= '0;
          end
        end
        S_ROUND: begin
          st_q <= rs[UNROLL];
          t_q  <= t_q + STEP;
          w_q  <= ws[0];
        end
        S_FINAL: cv_next_q <= cv_sum;
        default: ;
      endcase
    end
  end

`ifdef PREFETCH_EN
  logic [511:0] win_q;

  assign win = win_q;

  // Load buffer streams freely, even during compression
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    buf_q <= '0;
    else if (load) buf_q <= {buf_q[479:0], din};
  end

  // Schedule window snapshots the buffer at start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      win_q <= '0;
    else if (go)
      win_q <= buf_q;
    else if (state_q == S_ROUND)
      win_q <= win_adv;
  end
`else
  assign win = buf_q;

  // Shared buffer/window: start keeps it, rounds advance it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      buf_q <= '0;
    else if (state_q == S_ROUND)
      buf_q <= win_adv;
    else if (state_q == S_IDLE && load && !go)
      buf_q <= {buf_q[479:0], din};
  end
`endif

  assign busy    = (state_q != S_IDLE);
  assign ready   = ready_q;
  assign cv_next = cv_next_q;
  assign w       = (state_q == S_ROUND) ? ws[0] : w_q;

endmodule
